// File: rtl/ram_dp_param.sv
// ram_dp_param: one-write/one-read synchronous RAM with byte enables, write-first collisions, a reset zero-sweep (busy) and RD_LATENCY 1|2.
// Optional per-byte even parity under RAM_DP_PARITY_EN; no backpressure, one read result per cycle.
module ram_dp_param #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 1 << ADDR_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   wr_address,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    inj_par_err,
   input  logic                    read,
   input  logic [ADDR_WIDTH-1:0]   rd_address,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    parity_err
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {INIT, READY} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    parity_err_q, parity_err_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_wa;
   logic [DATA_WIDTH-1:0]   mem_wd;
   logic [BYTES-1:0]        mem_be;
   logic [IDX_W-1:0]        widx, ridx;
   logic                    ready, wr_in_range, rd_in_range, rd_acc, wr_hit;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_perr;
   logic                    o_vld, o_err;
   logic [DATA_WIDTH-1:0]   o_dat;

   assign ready       = (state_q == READY);
   assign busy        = (state_q == INIT);
   assign wr_in_range = ({1'b0, wr_address} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_address} < DEPTH_W);
   assign rd_acc      = ready && read;
   assign wr_hit      = ready && write && (wr_address == rd_address);
   assign widx        = mem_wa[IDX_W-1:0];
   assign ridx        = rd_address[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_ADDR) state_d = READY;
      end
   end

   // The sweep owns the write port while busy; user requests are dropped.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = wr_address;
      mem_wd = data_in;
      mem_be = wr_be;
      if (busy) begin
         mem_we = 1'b1;
         mem_wa = cnt_q;
         mem_wd = '0;
         mem_be = '1;
      end else if (write && wr_in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mem_be[i]) mem[widx][8*i +: 8] <= mem_wd[8*i +: 8];
         end
      end
   end

`ifdef RAM_DP_PARITY_EN
   logic [BYTES-1:0] par_mem [DEPTH];
   logic [BYTES-1:0] wr_par, rd_par;

   always_comb begin
      wr_par = '0;
      for (int i = 0; i < BYTES; i++) begin
         wr_par[i] = (^data_in[8*i +: 8]) ^ inj_par_err;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (mem_be[i]) par_mem[widx][i] <= busy ? 1'b0 : wr_par[i];
         end
      end
   end
`else
   logic unused_inj;
   assign unused_inj = inj_par_err;
`endif

   // Write-first: enabled bytes of a same-address write bypass into the captured word.
   always_comb begin
      rd_word = '0;
      rd_perr = 1'b0;
`ifdef RAM_DP_PARITY_EN
      rd_par  = '0;
`endif
      if (rd_in_range) begin
         rd_word = mem[ridx];
`ifdef RAM_DP_PARITY_EN
         rd_par  = par_mem[ridx];
`endif
         for (int i = 0; i < BYTES; i++) begin
            if (wr_hit && wr_be[i]) begin
               rd_word[8*i +: 8] = data_in[8*i +: 8];
`ifdef RAM_DP_PARITY_EN
               rd_par[i] = wr_par[i];
`endif
            end
         end
`ifdef RAM_DP_PARITY_EN
         for (int i = 0; i < BYTES; i++) begin
            if (rd_par[i] != (^rd_word[8*i +: 8])) rd_perr = 1'b1;
         end
`endif
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  p1_vld_q, p1_vld_d;
         logic [DATA_WIDTH-1:0] p1_dat_q, p1_dat_d;
         logic                  p1_err_q, p1_err_d;

         always_comb begin
            p1_vld_d = rd_acc;
            p1_dat_d = rd_word;
            p1_err_d = rd_perr;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               p1_vld_q <= 1'b0;
               p1_dat_q <= '0;
               p1_err_q <= 1'b0;
            end else begin
               p1_vld_q <= p1_vld_d;
               p1_dat_q <= p1_dat_d;
               p1_err_q <= p1_err_d;
            end
         end

         assign o_vld = p1_vld_q;
         assign o_dat = p1_dat_q;
         assign o_err = p1_err_q;
      end else begin : g_lat1
         assign o_vld = rd_acc;
         assign o_dat = rd_word;
         assign o_err = rd_perr;
      end
   endgenerate

   always_comb begin
      rd_valid_d   = o_vld;
      data_out_d   = o_vld ? o_dat : data_out_q;
      parity_err_d = o_vld && o_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= INIT;
         cnt_q        <= '0;
         data_out_q   <= '0;
         rd_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_out_q   <= data_out_d;
         rd_valid_q   <= rd_valid_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign rd_valid   = rd_valid_q;
   assign parity_err = parity_err_q;
endmodule
